// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 registers operands, S2 computes, clamps and holds the result.
// The S2 result register doubles as the accumulator used by ACC and hold beats.
module alu_pipe #(
    parameter int unsigned DATA_W = 5,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned OUT_W = DATA_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     alu_en,
    input  logic                     a_en,
    input  logic [2:0]               a_op,
    input  logic                     b_en,
    input  logic [1:0]               b_op,
    input  logic signed [DATA_W-1:0] A,
    input  logic signed [DATA_W-1:0] B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  C,
    output logic                     err,
    output logic                     sat,
    output logic [CNT_W-1:0]         err_cnt
);
    // Two guard bits cover acc + A + B without overflow before clamping.
    localparam int unsigned WIDE_W = OUT_W + 2;
    localparam logic signed [WIDE_W-1:0] MAX_V = {{3{1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] MIN_V = -MAX_V;

    logic                     s1_valid_q;
    logic                     s1_alu_en_q, s1_a_en_q, s1_b_en_q;
    logic [2:0]               s1_a_op_q;
    logic [1:0]               s1_b_op_q;
    logic signed [DATA_W-1:0] s1_a_q, s1_b_q;

    logic                     s2_valid_q;
    logic signed [OUT_W-1:0]  acc_q;
    logic                     err_q, sat_q;
    logic [CNT_W-1:0]         err_cnt_q;

    logic                     s1_load, s2_load;
    logic signed [WIDE_W-1:0] a_x, b_x, acc_x, res;
    logic                     arith, illegal, sat_d;
    logic signed [OUT_W-1:0]  c_d;

    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
    assign s1_load  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= 1'b1;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_alu_en_q <= alu_en;
            s1_a_en_q   <= a_en;
            s1_a_op_q   <= a_op;
            s1_b_en_q   <= b_en;
            s1_b_op_q   <= b_op;
            s1_a_q      <= A;
            s1_b_q      <= B;
        end
    end

    always_comb begin
        a_x     = {{(WIDE_W-DATA_W){s1_a_q[DATA_W-1]}}, s1_a_q};
        b_x     = {{(WIDE_W-DATA_W){s1_b_q[DATA_W-1]}}, s1_b_q};
        acc_x   = {{(WIDE_W-OUT_W){acc_q[OUT_W-1]}}, acc_q};
        res     = '0;
        arith   = 1'b0;
        illegal = 1'b0;
        if (!s1_alu_en_q) begin
            res = '0;
        end else if (s1_a_en_q && !s1_b_en_q) begin
            unique case (s1_a_op_q)
                3'd0:    begin res = a_x + b_x; arith = 1'b1; end
                3'd1:    begin res = a_x - b_x; arith = 1'b1; end
                3'd2:    res = a_x ^ b_x;
                3'd3:    res = a_x & b_x;
                3'd4:    res = a_x | b_x;
                3'd5:    res = ~(a_x ^ b_x);
                3'd6:    res = ~(a_x & b_x);
                default: illegal = 1'b1;
            endcase
        end else if (!s1_a_en_q && s1_b_en_q) begin
            unique case (s1_b_op_q)
                2'd0: res = ~(a_x | b_x);
                2'd1: begin res = a_x + b_x; arith = 1'b1; end
                2'd2: begin res = b_x - a_x; arith = 1'b1; end
                2'd3: illegal = 1'b1;
            endcase
        end else if (s1_a_en_q && s1_b_en_q) begin
            unique case (s1_b_op_q)
                2'd0: res = a_x ^ b_x;
                2'd1: res = ~(a_x ^ b_x);
                2'd2: begin res = a_x - b_x; arith = 1'b1; end
                2'd3: begin res = acc_x + a_x + b_x; arith = 1'b1; end
            endcase
        end else begin
            res = acc_x;
        end
    end

    // Symmetric clamp: the most negative code is never produced.
    always_comb begin
        sat_d = 1'b0;
        if (arith && (res > MAX_V)) begin
            c_d   = MAX_V[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (arith && (res < MIN_V)) begin
            c_d   = MIN_V[OUT_W-1:0];
            sat_d = 1'b1;
        end else begin
            c_d = res[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            acc_q      <= '0;
            err_q      <= 1'b0;
            sat_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            acc_q      <= c_d;
            err_q      <= illegal;
            sat_q      <= sat_d;
            if (illegal && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid = s2_valid_q;
    assign C         = acc_q;
    assign err       = err_q;
    assign sat       = sat_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results, monitor pops on each output beat.
module tb_alu_pipe;
    localparam int DATA_W  = 5;
    localparam int CNT_W   = 3;
    localparam int OUT_W   = DATA_W + 1;
    localparam int MAXV    = (1 << (OUT_W - 1)) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid, in_ready;
    logic                     alu_en, a_en, b_en;
    logic [2:0]               a_op;
    logic [1:0]               b_op;
    logic signed [DATA_W-1:0] A, B;
    logic                     out_valid, out_ready;
    logic signed [OUT_W-1:0]  C;
    logic                     err, sat;
    logic [CNT_W-1:0]         err_cnt;

    alu_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_en(alu_en), .a_en(a_en), .a_op(a_op), .b_en(b_en), .b_op(b_op),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .C(C), .err(err), .sat(sat), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit alu_en, a_en, b_en;
        bit [2:0] a_op;
        bit [1:0] b_op;
        int a, b;
    } beat_t;

    typedef struct {
        int c;
        bit err, sat;
        int cnt;
        int acc_cyc;
        bit lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   m_acc = 0, m_cnt = 0;
    bit   chk_lat = 0, rand_bp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic signed [31:0] act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference model: spec decode table on plain integers, accumulator as a running int.
    function automatic exp_t model(beat_t b);
        exp_t e;
        int   r = 0;
        e.err = 0;
        e.sat = 0;
        if (!b.alu_en) r = 0;
        else if (b.a_en && !b.b_en) begin
            case (b.a_op)
                0: r = b.a + b.b;
                1: r = b.a - b.b;
                2: r = b.a ^ b.b;
                3: r = b.a & b.b;
                4: r = b.a | b.b;
                5: r = ~(b.a ^ b.b);
                6: r = ~(b.a & b.b);
                default: e.err = 1;
            endcase
        end else if (!b.a_en && b.b_en) begin
            case (b.b_op)
                0: r = ~(b.a | b.b);
                1: r = b.a + b.b;
                2: r = b.b - b.a;
                default: e.err = 1;
            endcase
        end else if (b.a_en && b.b_en) begin
            case (b.b_op)
                0: r = b.a ^ b.b;
                1: r = ~(b.a ^ b.b);
                2: r = b.a - b.b;
                default: r = m_acc + b.a + b.b;
            endcase
        end else r = m_acc;
        if (e.err) begin
            r = 0;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        if (r > MAXV) begin r = MAXV; e.sat = 1; end
        if (r < -MAXV) begin r = -MAXV; e.sat = 1; end
        m_acc     = r;
        e.c       = r;
        e.cnt     = m_cnt;
        e.acc_cyc = cyc;
        e.lat     = chk_lat;
        return e;
    endfunction

    function automatic beat_t mk(bit en, bit ae, int ao, bit be, int bo, int a, int b);
        beat_t x;
        x.alu_en = en; x.a_en = ae; x.b_en = be;
        x.a_op = 3'(ao); x.b_op = 2'(bo);
        x.a = a; x.b = b;
        return x;
    endfunction

    function automatic beat_t rnd_beat();
        return mk($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                  int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16);
    endfunction

    task automatic drive(beat_t b);
        alu_en = b.alu_en; a_en = b.a_en; a_op = b.a_op;
        b_en = b.b_en; b_op = b.b_op;
        A = b.a[DATA_W-1:0];
        B = b.b[DATA_W-1:0];
        in_valid = 1'b1;
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(beat_t b);
        int guard = 0;
        drive(b);
        #1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck at %0b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(model(b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every presented beat must match the queue head; pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b0) continue;
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_beat: got C=%0d, expected no beat", C);
                end else begin
                    e = sb[0];
                    check("C", $signed(C), e.c);
                    check("err", err, int'(e.err));
                    check("sat", sat, int'(e.sat));
                    check("err_cnt", err_cnt, e.cnt);
                    if (out_ready) begin
                        if (e.lat) check("latency", cyc - e.acc_cyc, 2);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        alu_en = 1'b1; a_en = 1'b1; b_en = 1'b0; a_op = 3'd0; b_op = 2'd0;
        A = '0; B = '0;
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_C", $signed(C), 0);
            check("rst_err_cnt", err_cnt, 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        check("post_rst_no_beat", out_valid, 0);

        // Add / subtract with latency check
        chk_lat = 1;
        send(mk(1, 1, 0, 0, 0, 15, 15));
        send(mk(1, 1, 1, 0, 0, -16, 15));
        drain();
        chk_lat = 0;

        // Accumulate: zero the accumulator, chain, then hold
        send(mk(0, 0, 0, 0, 0, 0, 0));
        repeat (3) send(mk(1, 1, 0, 1, 3, 15, 15));
        send(mk(1, 1, 0, 1, 3, -16, -16));
        send(mk(1, 0, 0, 0, 0, 7, 7));
        drain();

        // Backpressure: only two beats may enter
        out_ready = 1'b0;
        send(mk(1, 1, 2, 0, 0, 5, -3));
        send(mk(1, 0, 0, 1, 2, 4, -9));
        drive(mk(1, 1, 4, 0, 0, -8, 3));
        repeat (3) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        check("bp_held", sb.size(), 2);
        out_ready = 1'b1;
        send(mk(1, 1, 4, 0, 0, -8, 3));
        send(mk(1, 1, 6, 0, 0, 6, 7));
        drain();

        // Reset, then illegal ops counting 0->1->2, then a legal beat
        rst = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("err_cnt_start", err_cnt, 0);
        send(mk(1, 1, 7, 0, 0, 3, 4));
        send(mk(1, 0, 0, 1, 3, 3, 4));
        send(mk(1, 1, 0, 0, 0, 1, 2));
        drain();
        check("err_cnt_after", err_cnt, 2);

        // Randomized traffic with random backpressure (counter saturates at CNT_MAX)
        rand_bp = 1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(rnd_beat());
        end
        rand_bp = 0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(mk(1, 1, 0, 0, 0, 3, 3));
        send(mk(1, 1, 0, 0, 0, 2, 2));
        rst = 1'b1;
        sb.delete();
        m_acc = 0;
        m_cnt = 0;
        @(negedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_C", $signed(C), 0);
        check("midrst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(mk(1, 1, 0, 1, 3, 5, 5));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 5-bit ALU. Operation decode uses alu_en/a_en/a_op/b_en/b_op.
- Adds a generic operand width, a valid/ready handshake with backpressure, a saturating accumulate mode and per-beat error/saturation flags.
- Sits between the stimulus/driver side and the result consumer; one result beat per accepted operand beat, in order.

Parameters:
- DATA_W, 5, signed operand width (>=3).
- OUT_W, DATA_W+1, signed result width. Fixed derivation; not overridable.
- CNT_W, 8, width of the illegal-op error counter.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- alu_en  input  1  ALU enable; 0 gives result 0.
- a_en  input  1  A-group op enable.
- a_op  input  3  A-group opcode.
- b_en  input  1  B-group op enable.
- b_op  input  2  B-group opcode.
- A  input  DATA_W  signed operand.
- B  input  DATA_W  signed operand.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result beat.
- C  output  OUT_W  signed result.
- err  output  1  beat carried an illegal opcode.
- sat  output  1  beat result was clamped.
- err_cnt  output  CNT_W  saturating count of illegal beats.

Behaviour:
- Reset: rst is sampled on posedge clk. Clears both stage valids, C, err, sat, err_cnt and acc_reg (the last-result register) to 0. in_ready=0 while rst=1.
- Reset mid-operation: in-flight beats are discarded, not emitted. The next ACC starts from 0.
- Handshake:
  - A beat transfers in when in_valid&&in_ready. It transfers out when out_valid&&out_ready.
  - in_valid/out_valid and their payloads hold until accepted.
- Pipeline:
  - S1 registers the inputs. S2 computes and registers C/err/sat.
  - Latency is 2 cycles from accept to out_valid.
  - Full throughput of 1 beat/cycle when out_ready=1.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - With out_ready=0, at most 2 beats are held, and C/err/sat stay stable.
- Computation:
  - Operands are sign-extended to OUT_W. Bitwise ops act on the extended values.
  - Arithmetic is full precision, then clamped to [-(2^(OUT_W-1)-1), +(2^(OUT_W-1)-1)]. The value -2^(OUT_W-1) is never produced. sat=1 when clamping occurred.
- Decode (priority top-down):
  - alu_en=0: C=0.
  - a_en=1, b_en=0, by a_op:
    - 0: A+B
    - 1: A-B
    - 2: A^B
    - 3: A&B
    - 4: A|B
    - 5: ~(A^B)
    - 6: ~(A&B)
    - 7: illegal
  - a_en=0, b_en=1, by b_op:
    - 0: ~(A|B)
    - 1: A+B
    - 2: B-A
    - 3: illegal
  - a_en=1, b_en=1, by b_op:
    - 0: A^B
    - 1: ~(A^B)
    - 2: A-B
    - 3: ACC = clamp(acc_reg+A+B)
  - a_en=0, b_en=0: C=acc_reg (hold); beat is still emitted.
- Illegal beat: C=0, err=1, err_cnt+1. err_cnt saturates at 2^CNT_W-1.
- acc_reg loads the S2 result on every S2 load, so back-to-back ACC beats chain correctly without bubbles. Illegal beats load 0 into acc_reg.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, C=0, err_cnt=0; no beat emitted after release.
- a_en=1, a_op=0, A=15, B=15 -> C=30 exactly 2 cycles after accept, sat=0. Then a_op=1, A=-16, B=15 -> C=-31.
- ACC (a_en=b_en=1, b_op=3):
  - Beats (15,15)x3 -> C=30 (sat=0), 31 (sat=1), 31 (sat=1).
  - Then (-16,-16) -> C=-1.
  - Then a_en=b_en=0 -> C=-1 (hold).
- Backpressure: out_ready=0, 4 beats offered -> 2 accepted, then in_ready=0 and C stable. Release out_ready -> all 4 results emerge in order, none lost or duplicated.
- Illegal ops: a_op=7 (a_en only) and b_op=3 (b_en only) -> each gives C=0, err=1; err_cnt goes 0->1->2. The following legal beat has err=0.
- Reset mid-stream: rst with 2 beats in flight -> next cycle out_valid=0, C=0. The first ACC (5,5) after release -> C=10.
